// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Sequential issue / write-back controller for a 16-bit combinational ALU.
// Holds an NREGS-entry register file. It accepts one instruction at a time
// over a valid/ready handshake, reads both operands, presents them to the
// ALU, captures the result and carry/borrow, and writes the result back.
// It also keeps a sticky overflow flag.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   instr_valid / instr_ready  instruction handshake
//   instr_cop/rd/ra/rb         opcode, destination and source registers
//   alu_reg_A/B, alu_cop       registered operands and opcode to the ALU
//   alu_result, alu_OVF        combinational ALU response
//   wb_valid/wb_rd/wb_data     one-cycle write-back report
//   illegal                    one-cycle pulse when an illegal cop is rejected
//   ovf_flag, ovf_clr          sticky overflow flag and its synchronous clear
//   dbg_addr, dbg_data         combinational register-file read port
//
// Optional feature macro: ALU_ISSUE_FWD_EN
//   When defined, a new instruction may also be accepted in WB. Operands
//   that match the register being written back are forwarded from
//   wb_data instead of being read from the register file.
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int INPUT_WIDTH = 16,
    parameter int NREGS       = 8,
    parameter int RA_W        = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [3:0]             instr_cop,
    input  logic [RA_W-1:0]        instr_rd,
    input  logic [RA_W-1:0]        instr_ra,
    input  logic [RA_W-1:0]        instr_rb,
    output logic [INPUT_WIDTH-1:0] alu_reg_A,
    output logic [INPUT_WIDTH-1:0] alu_reg_B,
    output logic [3:0]             alu_cop,
    input  logic [INPUT_WIDTH-1:0] alu_result,
    input  logic                   alu_OVF,
    output logic                   wb_valid,
    output logic [RA_W-1:0]        wb_rd,
    output logic [INPUT_WIDTH-1:0] wb_data,
    output logic                   illegal,
    output logic                   ovf_flag,
    input  logic                   ovf_clr,
    input  logic [RA_W-1:0]        dbg_addr,
    output logic [INPUT_WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [3:0] COP_ZERO = 4'b0000;
    localparam logic [3:0] COP_ADD  = 4'b0001;
    localparam logic [3:0] COP_SUB  = 4'b0010;
    localparam logic [3:0] COP_PASS = 4'b0011;
    localparam logic [3:0] COP_EQ   = 4'b0100;

    // Only the five ALU operations with a defined result may be issued.
    function automatic logic cop_is_legal(input logic [3:0] cop);
        logic legal;
        case (cop)
            COP_ZERO, COP_ADD, COP_SUB, COP_PASS, COP_EQ: legal = 1'b1;
            default:                                      legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] regfile_q [NREGS];
    logic [INPUT_WIDTH-1:0] regfile_d [NREGS];
    logic [INPUT_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [INPUT_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]             cop_q, cop_d;
    logic [RA_W-1:0]        rd_q, rd_d;
    logic                   wb_valid_q, wb_valid_d;
    logic [RA_W-1:0]        wb_rd_q, wb_rd_d;
    logic [INPUT_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                   illegal_q, illegal_d;
    logic                   ovf_q, ovf_d;
    logic                   ready_s;
    logic                   accept_s;
    logic                   ovf_set_s;
    logic [INPUT_WIDTH-1:0] opnd_a_s, opnd_b_s;

    // Ready decode: IDLE always; WB as well when forwarding is built in.
    always_comb begin
        ready_s = 1'b0;
        case (state_q)
            IDLE:    ready_s = 1'b1;
`ifdef ALU_ISSUE_FWD_EN
            WB:      ready_s = 1'b1;
`else
            WB:      ready_s = 1'b0;
`endif
            EXEC:    ready_s = 1'b0;
            default: ready_s = 1'b0;
        endcase
    end

    // Operand fetch; in WB the register being written has not landed yet,
    // so with forwarding enabled a matching source takes wb_data instead.
    always_comb begin
        opnd_a_s = regfile_q[instr_ra];
        opnd_b_s = regfile_q[instr_rb];
`ifdef ALU_ISSUE_FWD_EN
        if ((state_q == WB) && (instr_ra == wb_rd_q)) begin
            opnd_a_s = wb_data_q;
        end else begin
            opnd_a_s = regfile_q[instr_ra];
        end
        if ((state_q == WB) && (instr_rb == wb_rd_q)) begin
            opnd_b_s = wb_data_q;
        end else begin
            opnd_b_s = regfile_q[instr_rb];
        end
`endif
    end

    // Next-state, datapath and flag logic.
    always_comb begin
        state_d    = state_q;
        regfile_d  = regfile_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        cop_d      = cop_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        illegal_d  = 1'b0;
        ovf_set_s  = 1'b0;
        accept_s   = instr_valid & ready_s;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            EXEC: begin
                // Capture the ALU response; wb_* become visible in WB.
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_data_d  = alu_result;
                if (alu_OVF && ((cop_q == COP_ADD) || (cop_q == COP_SUB))) begin
                    ovf_set_s = 1'b1;
                end else begin
                    ovf_set_s = 1'b0;
                end
                state_d = WB;
            end
            WB: begin
                regfile_d[wb_rd_q] = wb_data_q;
                state_d            = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An accepted instruction overrides the default next state; an
        // illegal one only raises the pulse and lets the FSM fall to IDLE.
        if (accept_s) begin
            if (cop_is_legal(instr_cop)) begin
                alu_a_d = opnd_a_s;
                alu_b_d = opnd_b_s;
                cop_d   = instr_cop;
                rd_d    = instr_rd;
                state_d = EXEC;
            end else begin
                illegal_d = 1'b1;
            end
        end else begin
            illegal_d = 1'b0;
        end

        // Set beats clear when both land in the same cycle.
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            for (int i = 0; i < NREGS; i++) begin
                regfile_q[i] <= '0;
            end
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            cop_q      <= 4'd0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            regfile_q  <= regfile_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            cop_q      <= cop_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            illegal_q  <= illegal_d;
            ovf_q      <= ovf_d;
        end
    end

    assign instr_ready = ready_s;
    assign alu_reg_A   = alu_a_q;
    assign alu_reg_B   = alu_b_q;
    assign alu_cop     = cop_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign illegal     = illegal_q;
    assign ovf_flag    = ovf_q;
    assign dbg_data    = regfile_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl. The bench plays the part of the
// combinational 16-bit ALU. Register contents are built up through real
// instructions: r7 = (r0 == r0) = 1, and constants are made by
// doubling and adding r7.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_cop = 4'd0;
    logic [2:0]  instr_rd = 3'd0;
    logic [2:0]  instr_ra = 3'd0;
    logic [2:0]  instr_rb = 3'd0;
    logic [15:0] alu_reg_A;
    logic [15:0] alu_reg_B;
    logic [3:0]  alu_cop;
    logic [15:0] alu_result;
    logic        alu_OVF;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        illegal;
    logic        ovf_flag;
    logic        ovf_clr = 1'b0;
    logic [2:0]  dbg_addr = 3'd0;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    // Values seen during the most recent issue() call.
    logic        ex_wb_valid, ex_ready;
    logic        wb_seen, wb_ready_seen;
    logic [2:0]  wb_rd_seen;
    logic [15:0] wb_data_seen;
    logic        ovf_seen;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_cop(instr_cop), .instr_rd(instr_rd),
        .instr_ra(instr_ra), .instr_rb(instr_rb),
        .alu_reg_A(alu_reg_A), .alu_reg_B(alu_reg_B), .alu_cop(alu_cop),
        .alu_result(alu_result), .alu_OVF(alu_OVF),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // External ALU behaviour: 17-bit arithmetic gives carry / borrow.
    always_comb begin
        logic [16:0] wide;
        wide = 17'd0;
        case (alu_cop)
            4'b0000: wide = 17'd0;
            4'b0001: wide = {1'b0, alu_reg_A} + {1'b0, alu_reg_B};
            4'b0010: wide = {1'b0, alu_reg_A} - {1'b0, alu_reg_B};
            4'b0011: wide = {1'b0, alu_reg_B};
            4'b0100: wide = (alu_reg_A == alu_reg_B) ? 17'd1 : 17'd0;
            default: wide = {17{1'bx}};
        endcase
        alu_result = wide[15:0];
        alu_OVF    = wide[16];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic dbg_rd(input logic [2:0] addr, output logic [15:0] val);
        dbg_addr = addr;
        #1;
        val = dbg_data;
    endtask

    // Issue one instruction starting at a negedge; returns at a negedge
    // with the controller back in IDLE. clr_exec drives ovf_clr in EXEC.
    task automatic issue(input logic [3:0] cop, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input logic clr_exec);
        int n;
        n = 0;
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) begin
            checks++;
            errors++;
            $error("FAIL ready_timeout observed=0 expected=1");
        end
        instr_valid = 1'b1;
        instr_cop   = cop;
        instr_rd    = rd;
        instr_ra    = ra;
        instr_rb    = rb;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        ovf_clr     = clr_exec;
        ex_wb_valid = wb_valid;
        ex_ready    = instr_ready;
        @(posedge clk);
        #1;
        ovf_clr       = 1'b0;
        wb_seen       = wb_valid;
        wb_rd_seen    = wb_rd;
        wb_data_seen  = wb_data;
        wb_ready_seen = instr_ready;
        ovf_seen      = ovf_flag;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Build val in rd using r0 = 0 and r7 = 1 (shift-and-add).
    task automatic load_const(input logic [2:0] rd, input logic [15:0] val);
        bit started;
        started = 1'b0;
        issue(4'b0000, rd, 3'd0, 3'd0, 1'b0);
        for (int i = 15; i >= 0; i--) begin
            if (started) issue(4'b0001, rd, rd, rd, 1'b0);
            if (val[i]) begin
                issue(4'b0001, rd, rd, 3'd7, 1'b0);
                started = 1'b1;
            end
        end
    endtask

    initial begin
        logic [15:0] v;

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            dbg_rd(a[2:0], v);
            chk($sformatf("reset_r%0d", a), {16'd0, v}, 32'd0);
        end
        chk("reset_ovf", {31'd0, ovf_flag}, 32'd0);
        chk("reset_ready", {31'd0, instr_ready}, 32'd1);
        chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        chk("reset_alu_a", {16'd0, alu_reg_A}, 32'd0);

        // r7 = (r0 == r0) = 1
        issue(4'b0100, 3'd7, 3'd0, 3'd0, 1'b0);
        chk("eq_init_data", {16'd0, wb_data_seen}, 32'd1);
        chk("eq_init_rd", {29'd0, wb_rd_seen}, 32'd7);

        // 5 - 3 = 2
        load_const(3'd1, 16'h0005);
        load_const(3'd2, 16'h0003);
        dbg_rd(3'd1, v);
        chk("preload_r1", {16'd0, v}, 32'h5);
        dbg_rd(3'd2, v);
        chk("preload_r2", {16'd0, v}, 32'h3);
        issue(4'b0010, 3'd3, 3'd1, 3'd2, 1'b0);
        chk("sub_no_wb_in_exec", {31'd0, ex_wb_valid}, 32'd0);
        chk("sub_ready_exec", {31'd0, ex_ready}, 32'd0);
        chk("sub_wb_valid", {31'd0, wb_seen}, 32'd1);
        chk("sub_wb_rd", {29'd0, wb_rd_seen}, 32'd3);
        chk("sub_wb_data", {16'd0, wb_data_seen}, 32'h2);
`ifndef ALU_ISSUE_FWD_EN
        chk("sub_ready_wb", {31'd0, wb_ready_seen}, 32'd0);
`endif
        chk("sub_ovf", {31'd0, ovf_seen}, 32'd0);
        dbg_rd(3'd3, v);
        chk("sub_r3", {16'd0, v}, 32'h2);

        // r1 = 0 - 1 = 0xFFFF (borrow sets the flag), r2 = pass r7 = 1
        issue(4'b0010, 3'd1, 3'd0, 3'd7, 1'b0);
        chk("borrow_data", {16'd0, wb_data_seen}, 32'hFFFF);
        chk("borrow_ovf", {31'd0, ovf_seen}, 32'd1);
        issue(4'b0011, 3'd2, 3'd0, 3'd7, 1'b0);
        chk("pass_data", {16'd0, wb_data_seen}, 32'h1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("clr_after_borrow", {31'd0, ovf_flag}, 32'd0);

        // 0xFFFF + 1 = 0 with carry; then set and clear together; then clear
        issue(4'b0001, 3'd4, 3'd1, 3'd2, 1'b0);
        chk("add_wrap_data", {16'd0, wb_data_seen}, 32'h0);
        chk("add_wrap_ovf", {31'd0, ovf_seen}, 32'd1);
        issue(4'b0001, 3'd4, 3'd1, 3'd2, 1'b1);
        chk("set_beats_clr", {31'd0, ovf_seen}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("clr_alone", {31'd0, ovf_flag}, 32'd0);

        // Equality: equal and unequal operands
        load_const(3'd1, 16'h1234);
        load_const(3'd2, 16'h1234);
        issue(4'b0100, 3'd5, 3'd1, 3'd2, 1'b0);
        chk("eq_true", {16'd0, wb_data_seen}, 32'h1);
        load_const(3'd2, 16'h1235);
        issue(4'b0100, 3'd5, 3'd1, 3'd2, 1'b0);
        chk("eq_false", {16'd0, wb_data_seen}, 32'h0);

        // ra == rb == rd reads the old value: r3 = 2 + 2 = 4
        issue(4'b0001, 3'd3, 3'd3, 3'd3, 1'b0);
        chk("self_add", {16'd0, wb_data_seen}, 32'h4);

        // Illegal cop aimed at r3
        instr_valid = 1'b1;
        instr_cop   = 4'b0111;
        instr_rd    = 3'd3;
        instr_ra    = 3'd1;
        instr_rb    = 3'd2;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("illegal_pulse", {31'd0, illegal}, 32'd1);
        chk("illegal_ready", {31'd0, instr_ready}, 32'd1);
        chk("illegal_no_wb", {31'd0, wb_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("illegal_one_cycle", {31'd0, illegal}, 32'd0);
        chk("illegal_no_wb2", {31'd0, wb_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("illegal_no_wb3", {31'd0, wb_valid}, 32'd0);
        dbg_rd(3'd3, v);
        chk("illegal_r3_kept", {16'd0, v}, 32'h4);
        @(negedge clk);

`ifdef ALU_ISSUE_FWD_EN
        // r1 = 1 + 1 = 2, then r2 = r1 + r7 accepted in WB must see 2
        instr_valid = 1'b1;
        instr_cop = 4'b0001; instr_rd = 3'd1; instr_ra = 3'd7; instr_rb = 3'd7;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("fwd_ready_in_wb", {31'd0, instr_ready}, 32'd1);
        chk("fwd_first_data", {16'd0, wb_data}, 32'h2);
        instr_valid = 1'b1;
        instr_cop = 4'b0001; instr_rd = 3'd2; instr_ra = 3'd1; instr_rb = 3'd7;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        chk("fwd_operand_a", {16'd0, alu_reg_A}, 32'h2);
        @(posedge clk);
        #1;
        chk("fwd_second_rd", {29'd0, wb_rd}, 32'd2);
        chk("fwd_second_data", {16'd0, wb_data}, 32'h3);
        @(posedge clk);
        @(negedge clk);
`endif

        // Reset in the middle of EXEC aborts the write-back
        instr_valid = 1'b1;
        instr_cop = 4'b0001; instr_rd = 3'd6; instr_ra = 3'd7; instr_rb = 3'd7;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        #2;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort_no_wb_%0d", c), {31'd0, wb_valid}, 32'd0);
        end
        dbg_rd(3'd6, v);
        chk("abort_r6", {16'd0, v}, 32'h0);
        dbg_rd(3'd7, v);
        chk("abort_r7_cleared", {16'd0, v}, 32'h0);
        chk("abort_ready", {31'd0, instr_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential issue/write-back controller that drives the 16-bit combinational ALU (operands reg_A/reg_B, 4-bit cop; result and OVF returned).
- Owns an internal register file and accepts one instruction at a time over a valid/ready handshake.
- Reads operands, presents them to the ALU, captures result/OVF, and writes the result back.
- Keeps a sticky overflow flag.

Parameters:
- INPUT_WIDTH, 16, datapath width; must match the ALU.
- NREGS, 8, number of register-file entries.
- RA_W, 3, register address width; NREGS = 2**RA_W.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  controller can accept an instruction
- instr_cop  input  4  operation code passed to the ALU
- instr_rd  input  RA_W  destination register
- instr_ra  input  RA_W  source register A
- instr_rb  input  RA_W  source register B
- alu_reg_A  output  INPUT_WIDTH  ALU operand A
- alu_reg_B  output  INPUT_WIDTH  ALU operand B
- alu_cop  output  4  ALU operation code
- alu_result  input  INPUT_WIDTH  ALU result
- alu_OVF  input  1  ALU carry/borrow out
- wb_valid  output  1  one-cycle pulse on register write-back
- wb_rd  output  RA_W  register written
- wb_data  output  INPUT_WIDTH  value written
- illegal  output  1  one-cycle pulse when an illegal cop is rejected
- ovf_flag  output  1  sticky overflow flag
- ovf_clr  input  1  synchronous clear of ovf_flag
- dbg_addr  input  RA_W  debug read address
- dbg_data  output  INPUT_WIDTH  combinational read of the register file at dbg_addr

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All registers, alu_* outputs, wb_*, illegal and ovf_flag go to 0; instr_ready = 1 after reset deasserts.
  - Reset mid-operation aborts the instruction with no write-back.
- Legal cop values:
  - 0000: zero
  - 0001: A+B
  - 0010: A-B
  - 0011: pass B
  - 0100: equality, result 1/0
  - All others are illegal.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready at a clock edge:
    - If cop is legal: latch cop and rd; latch regfile[ra] into alu_reg_A and regfile[rb] into alu_reg_B; go to EXEC.
    - If cop is illegal: pulse illegal for 1 cycle, stay IDLE, leave regfile unchanged.
- EXEC:
  - instr_ready = 0.
  - alu_reg_A, alu_reg_B and alu_cop are held stable (registered).
  - At the end of the cycle, capture alu_result and alu_OVF; go to WB.
- WB:
  - instr_ready = 0.
  - regfile[rd] <= captured result.
  - wb_valid = 1, with wb_rd/wb_data showing the written value this cycle.
  - Next state is IDLE.
- Latency: 3 cycles from accept to the next instr_ready = 1 (accept edge, EXEC, WB). Throughput is 1 instruction per 3 cycles.
- ra == rb == rd is permitted; operands are read at accept, before write-back.
- alu_* outputs hold their last values outside EXEC; the ALU's x-default never reaches write-back because illegal cops are filtered at accept.
- ovf_flag:
  - Set in EXEC when alu_OVF=1 and cop is 0001 or 0010.
  - Cleared by ovf_clr.
  - If set and clear occur in the same cycle, set wins.
- dbg_data reflects the regfile after the write-back edge (no internal bypass).

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- When defined:
  - instr_ready is also 1 in WB, so a new instruction can be accepted during WB. Throughput becomes 1 instruction per 2 cycles.
  - If the new ra or rb equals the rd being written back, the write-back data is forwarded into alu_reg_A/alu_reg_B instead of the stale regfile value.
  - An illegal cop accepted in WB pulses illegal and returns to IDLE after WB completes.
- When undefined: instr_ready = 1 only in IDLE, with no forwarding logic.

Test Plan:
- Reset then dbg read of all addresses -> every dbg_data = 0, ovf_flag = 0, instr_ready = 1.
- r1=0x0005, r2=0x0003 preloaded (via cop 0001 from zeroed regs plus prior writes); issue cop 0010 rd=3 ra=1 rb=2 -> wb_valid 2 cycles after accept with wb_rd=3, wb_data=0x0002, ovf_flag stays 0.
- r1=0xFFFF, r2=0x0001; cop 0001 rd=4 -> wb_data=0x0000, ovf_flag=1. Then ovf_clr and a set on the same cycle -> ovf_flag stays 1. ovf_clr alone -> 0.
- r1=0x1234, r2=0x1234; cop 0100 rd=5 -> wb_data=0x0001. Then cop 0100 with r2=0x1235 -> wb_data=0x0000.
- cop 0111 with instr_valid=1 -> illegal pulses 1 cycle, no wb_valid, regfile unchanged, instr_ready remains 1.
- Assert reset during EXEC of cop 0001 rd=6 -> no wb_valid and r6 = 0. With ALU_ISSUE_FWD_EN: back-to-back cop 0001 rd=1 then ra=1 accepted in WB -> the second instruction uses the forwarded value.
